branch_ctrl: RTL and testbench
==============================

# branch_ctrl

Branch resolution controller for the 5-stage MIPS pipeline. Owns the architectural Z/V/N flag register written from EX, evaluates the ID-stage branch condition against it, detects flag hazards (branch in ID while the instruction in EX is writing flags), and sequences stall, PC redirect and IF/ID flush. It sits between the ID-stage decoder, the EX-stage ALU flag outputs and the PC mux.

## Interface
- ADDR_W, 32, width of PC/branch target.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- hold  in  1  global pipeline freeze (memory stall); freezes state and flag register.
- ex_flag_we  in  1  instruction in EX writes flags this cycle.
- ex_flags  in  3  flags from ALU, {Z,V,N} (bit 2 = Z, bit 1 = V, bit 0 = N).
- id_bran  in  1  instruction in ID is a conditional branch.
- id_cond  in  3  condition code of ID branch.
- id_target  in  ADDR_W  resolved branch target from ID.
- stall  out  1  hold PC and IF/ID, inject bubble into ID/EX.
- pc_sel  out  1  select pc_target as next PC.
- pc_target  out  ADDR_W  redirect address.
- if_id_flush  out  1  squash the instruction entering ID next cycle.
- flags_q  out  3  current flag register {Z,V,N}.

## Operation
- Condition codes: 0 EQ Z; 1 NE !Z; 2 GT !Z&!N; 3 LT N; 4 GE Z|!N; 5 LE Z|N; 6 VS V; 7 AL 1.
- Flag register: flags_q <= ex_flags when ex_flag_we & !hold; reset 3'b000.
- Effective flags: flags_q (without FLAG_FWD_EN).
- FSM states: IDLE, HAZ, REDIR.
- IDLE, id_bran=0: no outputs.
- IDLE, id_bran=1, ex_flag_we=1 (hazard): stall=1, no redirect, -> HAZ.
- IDLE, id_bran=1, no hazard: evaluate; taken -> pc_sel=1, pc_target=id_target, if_id_flush=1, -> REDIR; not taken -> stay IDLE.
- HAZ: flags_q now holds EX result; evaluate id_cond against flags_q; stall=0; taken -> redirect+flush, -> REDIR; else -> IDLE. ex_flag_we in HAZ is a bubble and is ignored for evaluation but still written if asserted.
- REDIR: ID holds the squashed slot; id_bran ignored; all outputs 0; -> IDLE.
- hold=1: state, flags_q frozen; stall, pc_sel, if_id_flush forced 0.
- pc_target = id_target while pc_sel=1, else 0.

## Timing
- Outputs stall/pc_sel/if_id_flush/pc_target are Mealy (combinational from state + inputs), valid same cycle as branch in ID.
- Taken branch, no hazard: 1 bubble. Taken with hazard: 1 stall + 1 bubble. Not taken with hazard: 1 stall.
- Flag update visible on flags_q the cycle after ex_flag_we.
- Reset: state IDLE, flags_q 000, all outputs 0 in the cycle rst is sampled and after; rst mid-HAZ/REDIR abandons the branch (no redirect).
- rst dominates hold.
- stall and pc_sel never asserted in the same cycle.

## Configuration
- FLAG_FWD_EN defined: effective flags = ex_flag_we ? ex_flags : flags_q; hazard never declared, HAZ unreachable; taken branch always 1 bubble.
- Undefined: behaviour as above (stall-on-hazard).

## Structure
- Shared package: condition-code constants (COND_EQ..COND_AL), flag bit indices (FLAG_Z=2, FLAG_V=1, FLAG_N=0), FSM state encoding.
- One sub-module: branch_cond_eval (combinational cond/flags -> taken) instantiated once; FSM, flag register and outputs in branch_ctrl.

## Test plan
- Reset: rst=1 with id_bran=1, cond=7 -> pc_sel=0, stall=0, flags_q=000; next cycle still IDLE.
- No hazard: flags_q=100, id_bran=1, cond=0, target=0x40 -> same cycle pc_sel=1, pc_target=0x40, if_id_flush=1; next cycle id_bran=1 ignored (REDIR), then IDLE.
- Hazard, no FLAG_FWD_EN: flags_q=000, ex_flag_we=1, ex_flags=001, id_bran=1, cond=3 -> stall=1; next cycle flags_q=001, pc_sel=1; cond=2 instead -> no redirect, back to IDLE.
- All conditions: cond 0..7 against flags 000,001,010,100 -> taken per table (e.g. cond 4 flags 001 -> 0, cond 5 flags 001 -> 1, cond 6 flags 010 -> 1).
- hold: hazard detected, hold=1 for 3 cycles -> stall/pc_sel 0, state HAZ, flags_q unchanged; hold release -> resolves next cycle.
- FLAG_FWD_EN: ex_flag_we=1, ex_flags=100, cond=0 -> pc_sel=1 same cycle, stall never 1.

Source files
------------

// File: rtl/branch_ctrl_pkg.sv
// Shared definitions for the branch resolution controller: condition codes,
// flag bit positions and FSM state encoding.
package branch_ctrl_pkg;

    localparam logic [2:0] COND_EQ = 3'd0;
    localparam logic [2:0] COND_NE = 3'd1;
    localparam logic [2:0] COND_GT = 3'd2;
    localparam logic [2:0] COND_LT = 3'd3;
    localparam logic [2:0] COND_GE = 3'd4;
    localparam logic [2:0] COND_LE = 3'd5;
    localparam logic [2:0] COND_VS = 3'd6;
    localparam logic [2:0] COND_AL = 3'd7;

    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HAZ   = 2'd1,
        ST_REDIR = 2'd2
    } state_t;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition evaluation: condition code + {Z,V,N} -> taken.
module branch_cond_eval
    import branch_ctrl_pkg::*;
(
    input  logic [2:0] cond,
    input  logic [2:0] flags,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_EQ: taken = flags[FLAG_Z];
            COND_NE: taken = !flags[FLAG_Z];
            COND_GT: taken = !flags[FLAG_Z] && !flags[FLAG_N];
            COND_LT: taken = flags[FLAG_N];
            COND_GE: taken = flags[FLAG_Z] || !flags[FLAG_N];
            COND_LE: taken = flags[FLAG_Z] || flags[FLAG_N];
            COND_VS: taken = flags[FLAG_V];
            COND_AL: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_ctrl.sv
// Branch resolution controller: flag register, flag-hazard stall, PC redirect
// and IF/ID flush. Define FLAG_FWD_EN to forward EX flags instead of stalling.
module branch_ctrl
    import branch_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    input  logic              ex_flag_we,
    input  logic [2:0]        ex_flags,
    input  logic              id_bran,
    input  logic [2:0]        id_cond,
    input  logic [ADDR_W-1:0] id_target,
    output logic              stall,
    output logic              pc_sel,
    output logic [ADDR_W-1:0] pc_target,
    output logic              if_id_flush,
    output logic [2:0]        flags_q
);

    state_t     state_q;
    state_t     state_d;
    logic [2:0] eff_flags;
    logic       hazard;
    logic       taken;

`ifdef FLAG_FWD_EN
    assign eff_flags = ex_flag_we ? ex_flags : flags_q;
    assign hazard    = 1'b0;
`else
    // In HAZ the EX result has already landed in flags_q, so no bypass is needed.
    assign eff_flags = flags_q;
    assign hazard    = ex_flag_we;
`endif

    branch_cond_eval u_cond_eval (
        .cond  (id_cond),
        .flags (eff_flags),
        .taken (taken)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            flags_q <= 3'b000;
        end else if (!hold) begin
            state_q <= state_d;
            if (ex_flag_we) begin
                flags_q <= ex_flags;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        stall       = 1'b0;
        pc_sel      = 1'b0;
        if_id_flush = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (id_bran) begin
                    if (hazard) begin
                        stall   = 1'b1;
                        state_d = ST_HAZ;
                    end else if (taken) begin
                        pc_sel      = 1'b1;
                        if_id_flush = 1'b1;
                        state_d     = ST_REDIR;
                    end
                end
            end
            ST_HAZ: begin
                if (taken) begin
                    pc_sel      = 1'b1;
                    if_id_flush = 1'b1;
                    state_d     = ST_REDIR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REDIR: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        // Reset abandons any branch in flight; a freeze must not leak control pulses.
        if (rst || hold) begin
            stall       = 1'b0;
            pc_sel      = 1'b0;
            if_id_flush = 1'b0;
        end
    end

    assign pc_target = pc_sel ? id_target : '0;

endmodule

// File: tb/tb_branch_ctrl.sv
// Scoreboard bench for branch_ctrl: driver queues expected outputs per cycle,
// monitor pops and compares mid-cycle.
module tb_branch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hold = 1'b0;
    logic        ex_flag_we = 1'b0;
    logic [2:0]  ex_flags = 3'b000;
    logic        id_bran = 1'b0;
    logic [2:0]  id_cond = 3'd0;
    logic [31:0] id_target = 32'h0;
    logic        stall;
    logic        pc_sel;
    logic [31:0] pc_target;
    logic        if_id_flush;
    logic [2:0]  flags_q;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic        stall;
        logic        pc_sel;
        logic        flush;
        logic [31:0] tgt;
        logic [2:0]  fq;
        string       name;
    } exp_t;

    exp_t exp_q[$];

    branch_ctrl #(.ADDR_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .hold        (hold),
        .ex_flag_we  (ex_flag_we),
        .ex_flags    (ex_flags),
        .id_bran     (id_bran),
        .id_cond     (id_cond),
        .id_target   (id_target),
        .stall       (stall),
        .pc_sel      (pc_sel),
        .pc_target   (pc_target),
        .if_id_flush (if_id_flush),
        .flags_q     (flags_q)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic r, input logic h, input logic b,
                         input logic [2:0] c, input logic [31:0] t,
                         input logic we, input logic [2:0] fl,
                         input logic es, input logic ep, input logic ef,
                         input logic [2:0] efq, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; hold = h; id_bran = b; id_cond = c; id_target = t;
        ex_flag_we = we; ex_flags = fl;
        e.stall = es; e.pc_sel = ep; e.flush = ef;
        e.tgt = ep ? t : 32'h0;
        e.fq = efq; e.name = nm;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (stall !== e.stall || pc_sel !== e.pc_sel || if_id_flush !== e.flush ||
                pc_target !== e.tgt || flags_q !== e.fq) begin
                fails++;
                $display("FAIL %s: got stall=%b pc_sel=%b flush=%b tgt=%h flags=%b, want stall=%b pc_sel=%b flush=%b tgt=%h flags=%b",
                         e.name, stall, pc_sel, if_id_flush, pc_target, flags_q,
                         e.stall, e.pc_sel, e.flush, e.tgt, e.fq);
            end
            checks++;
            if (stall === 1'b1 && pc_sel === 1'b1) begin
                fails++;
                $display("FAIL excl_%s: got stall=1 pc_sel=1, want not both", e.name);
            end
        end
    end

    logic [7:0] tbl  [4];
    logic [2:0] pats [4];

    initial begin
        logic [2:0] prev;
        logic       tk;
        tbl[0] = 8'h96; pats[0] = 3'b000;
        tbl[1] = 8'hAA; pats[1] = 3'b001;
        tbl[2] = 8'hD6; pats[2] = 3'b010;
        tbl[3] = 8'hB1; pats[3] = 3'b100;

        // args: rst hold bran cond target we flags | stall pc_sel flush flags_q
        drive(1, 0, 1, 3'd7, 32'h10, 1, 3'b111, 0, 0, 0, 3'b000, "reset_al");
        drive(0, 0, 1, 3'd7, 32'h10, 0, 3'b000, 0, 1, 1, 3'b000, "post_reset_idle");
        drive(0, 0, 1, 3'd7, 32'h10, 0, 3'b000, 0, 0, 0, 3'b000, "redir_ignore");
        drive(0, 0, 0, 3'd0, 32'h0,  1, 3'b100, 0, 0, 0, 3'b000, "set_z");
        drive(0, 0, 1, 3'd0, 32'h40, 0, 3'b000, 0, 1, 1, 3'b100, "eq_taken");
        drive(0, 0, 1, 3'd0, 32'h40, 0, 3'b000, 0, 0, 0, 3'b100, "redir_slot");
        drive(0, 0, 1, 3'd1, 32'h44, 0, 3'b000, 0, 0, 0, 3'b100, "ne_not_taken");
        drive(0, 0, 0, 3'd0, 32'h0,  1, 3'b000, 0, 0, 0, 3'b100, "clr_flags");
`ifdef FLAG_FWD_EN
        drive(0, 0, 1, 3'd0, 32'h40, 1, 3'b100, 0, 1, 1, 3'b000, "fwd_eq_taken");
        drive(0, 0, 1, 3'd0, 32'h40, 0, 3'b000, 0, 0, 0, 3'b100, "fwd_redir");
        drive(0, 0, 1, 3'd3, 32'h48, 1, 3'b000, 0, 0, 0, 3'b100, "fwd_lt_not_taken");
        drive(0, 0, 0, 3'd0, 32'h0,  0, 3'b000, 0, 0, 0, 3'b000, "fwd_idle");
`else
        drive(0, 0, 1, 3'd3, 32'h80, 1, 3'b001, 1, 0, 0, 3'b000, "haz_lt_stall");
        drive(0, 0, 1, 3'd3, 32'h80, 0, 3'b000, 0, 1, 1, 3'b001, "haz_lt_taken");
        drive(0, 0, 0, 3'd0, 32'h0,  0, 3'b000, 0, 0, 0, 3'b001, "haz_redir");
        drive(0, 0, 1, 3'd2, 32'h90, 1, 3'b001, 1, 0, 0, 3'b001, "haz_gt_stall");
        drive(0, 0, 1, 3'd2, 32'h90, 1, 3'b010, 0, 0, 0, 3'b001, "haz_gt_not_taken");
        drive(0, 0, 1, 3'd6, 32'hA0, 0, 3'b000, 0, 1, 1, 3'b010, "vs_taken");
        drive(0, 0, 0, 3'd0, 32'h0,  0, 3'b000, 0, 0, 0, 3'b010, "vs_redir");
        drive(0, 0, 1, 3'd7, 32'hB0, 1, 3'b100, 1, 0, 0, 3'b010, "hold_haz_stall");
        drive(0, 1, 1, 3'd7, 32'hB0, 1, 3'b001, 0, 0, 0, 3'b100, "hold_1");
        drive(0, 1, 1, 3'd7, 32'hB0, 1, 3'b001, 0, 0, 0, 3'b100, "hold_2");
        drive(0, 1, 1, 3'd7, 32'hB0, 1, 3'b001, 0, 0, 0, 3'b100, "hold_3");
        drive(0, 0, 1, 3'd7, 32'hB0, 0, 3'b000, 0, 1, 1, 3'b100, "hold_release");
        drive(0, 0, 0, 3'd0, 32'h0,  0, 3'b000, 0, 0, 0, 3'b100, "hold_redir");
        drive(0, 0, 1, 3'd0, 32'hC0, 1, 3'b100, 1, 0, 0, 3'b100, "rst_haz_stall");
        drive(1, 0, 1, 3'd0, 32'hC0, 0, 3'b000, 0, 0, 0, 3'b100, "rst_mid_haz");
        drive(0, 0, 0, 3'd0, 32'h0,  0, 3'b000, 0, 0, 0, 3'b000, "after_rst");
        drive(0, 0, 1, 3'd1, 32'hD0, 1, 3'b100, 1, 0, 0, 3'b000, "after_rst_idle");
        drive(0, 0, 1, 3'd1, 32'hD0, 0, 3'b000, 0, 0, 0, 3'b100, "after_rst_haz_nt");
        drive(1, 1, 1, 3'd7, 32'hE0, 0, 3'b000, 0, 0, 0, 3'b100, "rst_over_hold");
        drive(0, 0, 0, 3'd0, 32'h0,  0, 3'b000, 0, 0, 0, 3'b000, "rst_over_hold_q");
`endif
        prev = 3'b000;
        for (int p = 0; p < 4; p++) begin
            drive(0, 0, 0, 3'd0, 32'h0, 1, pats[p], 0, 0, 0, prev,
                  $sformatf("tbl_set_%0d", p));
            for (int c = 0; c < 8; c++) begin
                tk = tbl[p][c];
                drive(0, 0, 1, 3'(c), 32'h100 + 32'(c), 0, 3'b000, 0, tk, tk, pats[p],
                      $sformatf("tbl_f%b_c%0d", pats[p], c));
                if (tk) begin
                    drive(0, 0, 0, 3'd0, 32'h0, 0, 3'b000, 0, 0, 0, pats[p],
                          $sformatf("tbl_redir_f%b_c%0d", pats[p], c));
                end
            end
            prev = pats[p];
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, want finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
